// File: rtl/cpu_defs.sv
// Shared pipeline definitions: forwarding selects, Tuse/Tnew encodings,
// HI/LO latency defaults and the basic hazard comparison.
package cpu_defs;

    localparam int TNEW_W = 2;
    typedef logic [TNEW_W-1:0] tnew_t;

    localparam logic [1:0] FWD_GRF = 2'd0;
    localparam logic [1:0] FWD_E   = 2'd1;
    localparam logic [1:0] FWD_M   = 2'd2;
    localparam logic [1:0] FWD_W   = 2'd3;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam int MULT_LAT_DEFAULT = 5;
    localparam int DIV_LAT_DEFAULT  = 10;

    // Operand src must wait on producer dst if the value is needed before it is made.
    function automatic logic src_wait(input logic [4:0] src, input logic [1:0] tuse,
                                      input logic [4:0] dst, input tnew_t tnew);
        return (src != 5'd0) && (tuse != TUSE_NONE) && (dst == src) && (tuse < tnew);
    endfunction

endpackage

// File: rtl/md_timer.sv
// HI/LO busy timer: loaded on an accepted mult/div start, counts down to zero.
module md_timer #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int LAT_W = $clog2(DIV_LAT + 1);

    logic [LAT_W-1:0] timer;

    assign busy = (timer != '0);

    // A start arriving while busy is dropped; the running count is not reloaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
        end else if (start && !busy) begin
            timer <= is_div ? LAT_W'(DIV_LAT) : LAT_W'(MULT_LAT);
        end else if (busy) begin
            timer <= timer - LAT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: stall/bubble generation,
// forwarding selects, HI/LO busy tracking and saturating stall counters.
module hazard_ctrl
    import cpu_defs::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEFAULT,
    parameter int DIV_LAT  = DIV_LAT_DEFAULT,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       d_rs,
    input  logic [4:0]       d_rt,
    input  logic [1:0]       d_tuse_rs,
    input  logic [1:0]       d_tuse_rt,
    input  logic             d_is_md,
    input  logic [4:0]       e_rs,
    input  logic [4:0]       e_rt,
    input  logic [4:0]       m_rt,
    input  logic [4:0]       e_dst,
    input  logic [4:0]       m_dst,
    input  logic [4:0]       w_dst,
    input  tnew_t            e_tnew,
    input  tnew_t            m_tnew,
    input  logic             e_md_start,
    input  logic             e_md_div,
    output logic             pc_en,
    output logic             fd_en,
    output logic             de_clr,
    output logic             md_busy,
    output logic [1:0]       fwd_d_rs,
    output logic [1:0]       fwd_d_rt,
    output logic [1:0]       fwd_e_rs,
    output logic [1:0]       fwd_e_rt,
    output logic [1:0]       fwd_m_rt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] md_stall_cnt
);

    logic data_stall, md_stall, stall;

    md_timer #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) u_md_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (e_md_start),
        .is_div (e_md_div),
        .busy   (md_busy)
    );

    // D operand: nearest ready producer wins; W is covered by GRF write-through.
    function automatic logic [1:0] sel_d(input logic [4:0] s, input logic [4:0] ed,
                                         input tnew_t et, input logic [4:0] md,
                                         input tnew_t mt);
        if (s == 5'd0)                 return FWD_GRF;
        if (ed == s && et == tnew_t'(0)) return FWD_E;
        if (md == s && mt == tnew_t'(0)) return FWD_M;
        return FWD_GRF;
    endfunction

    // E operand: M if ready, else W, else the D/E pipe register.
    function automatic logic [1:0] sel_e(input logic [4:0] s, input logic [4:0] md,
                                         input tnew_t mt, input logic [4:0] wd);
        if (s == 5'd0)                 return FWD_GRF;
        if (md == s && mt == tnew_t'(0)) return FWD_M;
        if (wd == s)                   return FWD_W;
        return FWD_GRF;
    endfunction

    // Stall detection and forwarding selects; reset forces the free-running state.
    always_comb begin
        data_stall = 1'b0;
        md_stall   = 1'b0;
        stall      = 1'b0;
        fwd_d_rs   = FWD_GRF;
        fwd_d_rt   = FWD_GRF;
        fwd_e_rs   = FWD_GRF;
        fwd_e_rt   = FWD_GRF;
        fwd_m_rt   = FWD_GRF;
        if (!reset) begin
            data_stall = src_wait(d_rs, d_tuse_rs, e_dst, e_tnew)
                       | src_wait(d_rs, d_tuse_rs, m_dst, m_tnew)
                       | src_wait(d_rt, d_tuse_rt, e_dst, e_tnew)
                       | src_wait(d_rt, d_tuse_rt, m_dst, m_tnew);
            md_stall   = d_is_md && (md_busy || e_md_start);
            stall      = data_stall || md_stall;
            fwd_d_rs   = sel_d(d_rs, e_dst, e_tnew, m_dst, m_tnew);
            fwd_d_rt   = sel_d(d_rt, e_dst, e_tnew, m_dst, m_tnew);
            fwd_e_rs   = sel_e(e_rs, m_dst, m_tnew, w_dst);
            fwd_e_rt   = sel_e(e_rt, m_dst, m_tnew, w_dst);
            fwd_m_rt   = (m_rt != 5'd0 && w_dst == m_rt) ? FWD_W : FWD_GRF;
        end
    end

    assign pc_en  = ~stall;
    assign fd_en  = ~stall;
    assign de_clr = stall;

    // Saturating stall counters; HI/LO count only when no data hazard is also present.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt    <= '0;
            md_stall_cnt <= '0;
        end else begin
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (md_stall && !data_stall && md_stall_cnt != '1)
                md_stall_cnt <= md_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: the driver pushes hand-computed expectations
// into a queue, a negedge monitor pops and compares against the DUT outputs.
module tb_hazard_ctrl;

    logic       clk, reset;
    logic [4:0] d_rs, d_rt, e_rs, e_rt, m_rt, e_dst, m_dst, w_dst;
    logic [1:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
    logic       d_is_md, e_md_start, e_md_div;
    logic       pc_en, fd_en, de_clr, md_busy;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;
    logic [3:0] stall_cnt, md_stall_cnt;

    hazard_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_is_md(d_is_md), .e_rs(e_rs), .e_rt(e_rt), .m_rt(m_rt),
        .e_dst(e_dst), .m_dst(m_dst), .w_dst(w_dst),
        .e_tnew(e_tnew), .m_tnew(m_tnew),
        .e_md_start(e_md_start), .e_md_div(e_md_div),
        .pc_en(pc_en), .fd_en(fd_en), .de_clr(de_clr), .md_busy(md_busy),
        .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt), .fwd_e_rs(fwd_e_rs),
        .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt),
        .stall_cnt(stall_cnt), .md_stall_cnt(md_stall_cnt)
    );

    typedef struct {
        string      name;
        logic       stall;
        logic       busy;
        logic [1:0] fdrs, fdrt, fers, fert, fmrt;
        int         sc;
        int         msc;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every queued expectation is compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.name, ".pc_en"},    int'(pc_en),    int'(!e.stall));
            chk({e.name, ".fd_en"},    int'(fd_en),    int'(!e.stall));
            chk({e.name, ".de_clr"},   int'(de_clr),   int'(e.stall));
            chk({e.name, ".md_busy"},  int'(md_busy),  int'(e.busy));
            chk({e.name, ".fwd_d_rs"}, int'(fwd_d_rs), int'(e.fdrs));
            chk({e.name, ".fwd_d_rt"}, int'(fwd_d_rt), int'(e.fdrt));
            chk({e.name, ".fwd_e_rs"}, int'(fwd_e_rs), int'(e.fers));
            chk({e.name, ".fwd_e_rt"}, int'(fwd_e_rt), int'(e.fert));
            chk({e.name, ".fwd_m_rt"}, int'(fwd_m_rt), int'(e.fmrt));
            if (e.sc >= 0)  chk({e.name, ".stall_cnt"},    int'(stall_cnt),    e.sc);
            if (e.msc >= 0) chk({e.name, ".md_stall_cnt"}, int'(md_stall_cnt), e.msc);
        end
    end

    task automatic push(input string nm, input logic st, input logic bz,
                        input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                        input logic [1:0] d, input logic [1:0] f,
                        input int sc = -1, input int msc = -1);
        exp_t e;
        e.name = nm; e.stall = st; e.busy = bz;
        e.fdrs = a; e.fdrt = b; e.fers = c; e.fert = d; e.fmrt = f;
        e.sc = sc; e.msc = msc;
        sb.push_back(e);
    endtask

    task automatic clr();
        d_rs = 0; d_rt = 0; d_tuse_rs = 3; d_tuse_rt = 3; d_is_md = 0;
        e_rs = 0; e_rt = 0; m_rt = 0; e_dst = 0; m_dst = 0; w_dst = 0;
        e_tnew = 0; m_tnew = 0; e_md_start = 0; e_md_div = 0;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        clr();
    endtask

    // Two reset cycles; the second one drives hazardous inputs that reset must mask.
    task automatic do_reset();
        adv();
        reset = 1;
        adv();
        d_rs = 1; d_tuse_rs = 0; e_dst = 1; e_tnew = 2; e_rs = 1; m_dst = 1;
        w_dst = 2; e_rt = 2; m_rt = 2; d_is_md = 1; e_md_start = 1;
        push("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        adv();
        reset = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, queue=%0d expected 0", sb.size());
        $fatal(1);
    end

    initial begin
        reset = 1;
        clr();

        // Data hazards and D/E/M forwarding
        do_reset();
        d_rs = 1; d_tuse_rs = 0; e_dst = 1; e_tnew = 2;
        push("lw_e", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        adv(); d_rs = 1; d_tuse_rs = 0; m_dst = 1; m_tnew = 1;
        push("lw_m", 1, 0, 0, 0, 0, 0, 0);
        adv(); d_rs = 1; d_tuse_rs = 0; m_dst = 1; m_tnew = 0;
        push("lw_fwd_m", 0, 0, 2, 0, 0, 0, 0, 2, 0);
        adv(); d_rs = 1; d_tuse_rs = 1; e_dst = 1; e_tnew = 2;
        push("tuse1_e", 1, 0, 0, 0, 0, 0, 0);
        adv(); d_rs = 1; d_tuse_rs = 1; m_dst = 1; m_tnew = 1;
        push("tuse1_m", 0, 0, 0, 0, 0, 0, 0);
        adv(); d_rs = 0; d_tuse_rs = 0; e_dst = 0; e_tnew = 2;
        push("reg0", 0, 0, 0, 0, 0, 0, 0);
        adv(); d_rt = 5; d_tuse_rt = 0; e_dst = 5; m_dst = 5;
        push("e_beats_m", 0, 0, 0, 1, 0, 0, 0);
        adv(); d_rs = 2; d_tuse_rs = 3; e_dst = 2; e_tnew = 2;
        push("tuse_none", 0, 0, 0, 0, 0, 0, 0, 3, 0);
        adv(); d_rt = 7; d_tuse_rt = 0; m_dst = 7; m_tnew = 1;
        push("rt_m_stall", 1, 0, 0, 0, 0, 0, 0);
        adv(); e_rs = 3; e_rt = 4; m_rt = 4; m_dst = 3; w_dst = 4;
        push("e_fwd_mw", 0, 0, 0, 0, 2, 3, 3);
        adv(); e_rs = 6; e_rt = 6; m_rt = 6; m_dst = 6; w_dst = 6;
        push("m_beats_w", 0, 0, 0, 0, 2, 2, 3);
        adv(); e_rs = 6; m_dst = 6; m_tnew = 1; w_dst = 6;
        push("m_not_ready", 0, 0, 0, 0, 3, 0, 0);
        adv();
        push("all_zero", 0, 0, 0, 0, 0, 0, 0, 4, 0);

        // mult: start at c10 with mflo in D -> stall c10..c15
        do_reset();
        repeat (10) adv();
        d_is_md = 1; e_md_start = 1; e_md_div = 0;
        push("mult_start", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 11; c <= 15; c++) begin
            adv(); d_is_md = 1;
            push("mult_busy", 1, 1, 0, 0, 0, 0, 0);
        end
        adv(); d_is_md = 1;
        push("mult_done", 0, 0, 0, 0, 0, 0, 0, 6, 6);

        // div: stall c10..c20; restart at c12 ignored; data hazard at c13 not md-counted
        do_reset();
        repeat (10) adv();
        d_is_md = 1; e_md_start = 1; e_md_div = 1;
        push("div_start", 1, 0, 0, 0, 0, 0, 0);
        for (int c = 11; c <= 20; c++) begin
            adv(); d_is_md = 1;
            if (c == 12) begin e_md_start = 1; e_md_div = 0; end
            if (c == 13) begin d_rs = 1; d_tuse_rs = 0; e_dst = 1; e_tnew = 1; end
            push("div_busy", 1, 1, 0, 0, 0, 0, 0);
        end
        adv(); d_is_md = 1;
        push("div_done", 0, 0, 0, 0, 0, 0, 0, 11, 10);

        // reset in the middle of a div
        do_reset();
        repeat (10) adv();
        d_is_md = 1; e_md_start = 1; e_md_div = 1;
        push("rdiv_start", 1, 0, 0, 0, 0, 0, 0);
        adv(); d_is_md = 1;
        push("rdiv_busy", 1, 1, 0, 0, 0, 0, 0, 1, 1);
        adv(); d_is_md = 1; reset = 1;
        push("rdiv_reset", 0, 1, 0, 0, 0, 0, 0, 2, 2);
        adv(); d_is_md = 1; reset = 0;
        push("rdiv_after", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // counter saturation: 19 stalled cycles with a 4-bit counter
        do_reset();
        for (int i = 0; i < 19; i++) begin
            d_rs = 1; d_tuse_rs = 0; e_dst = 1; e_tnew = 1;
            push("sat_stall", 1, 0, 0, 0, 0, 0, 0, (i <= 15) ? i : 15, 0);
            adv();
        end
        push("sat_hold", 0, 0, 0, 0, 0, 0, 0, 15, 0);

        adv();
        adv();
        chk("queue_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
